// File: rtl/sobel_frame_writer_pkg.sv
// Shared definitions for the sobel frame writer.
//   fw_state_t    : frame-writer FSM encoding (2 bits)
//   clog2/width_of: address/counter width helpers (width_of never returns 0)
//   total_words   : number of memory words in one frame
//   LANE0_IS_LSB  : packing order, first pixel of a word lands in the low lane
package sobel_frame_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } fw_state_t;

    localparam bit LANE0_IS_LSB = 1'b1;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int total_words(input int width, input int height, input int ppw);
        return (width * height) / ppw;
    endfunction

endpackage

// File: rtl/sobel_frame_writer_if.sv
// Bus bundle between the frame writer, the sobel output FIFO (show-ahead read
// side) and the word-write memory port.
//   in_rd_en / in_dout / in_empty        : FIFO pop strobe, head data, empty flag
//   mem_wr_en / mem_addr / mem_wr_data   : write request, word address, packed data
//   mem_wr_ready                         : memory accepts the write this cycle
// master = frame writer, slave = FIFO + memory side.
interface sobel_frame_writer_if #(
    parameter int PIXEL_DWIDTH    = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int ADDR_WIDTH      = 20
);
    logic                                    in_rd_en;
    logic [PIXEL_DWIDTH-1:0]                 in_dout;
    logic                                    in_empty;
    logic                                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]                   mem_addr;
    logic [PIXEL_DWIDTH*PIXELS_PER_WORD-1:0] mem_wr_data;
    logic                                    mem_wr_ready;

    modport master (
        output in_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        input  in_dout, in_empty, mem_wr_ready
    );

    modport slave (
        input  in_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        output in_dout, in_empty, mem_wr_ready
    );
endinterface

// File: rtl/sobel_frame_writer_pixel_packer.sv
// Collects PIXELS_PER_WORD pixels into one word.
//   clock, reset : clock, async active-low reset
//   push         : accept pixel this cycle
//   clear        : drop any partial word, restart at lane 0
//   pixel        : incoming pixel
//   word_next    : word including the pixel being pushed this cycle
//   word_full    : this push completes a word (word_next is then complete)
// Pixels shift in from the top, so after a full word lane 0 (LSBs) holds the
// first pixel pushed.
module sobel_frame_writer_pixel_packer
    import sobel_frame_writer_pkg::*;
#(
    parameter int PIXEL_DWIDTH    = 8,
    parameter int PIXELS_PER_WORD = 4,
    localparam int WORD_W         = PIXEL_DWIDTH * PIXELS_PER_WORD,
    localparam int IDX_W          = width_of(PIXELS_PER_WORD)
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    clear,
    input  logic [PIXEL_DWIDTH-1:0] pixel,
    output logic [WORD_W-1:0]       word_next,
    output logic                    word_full
);
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;

    assign word_next = LANE0_IS_LSB ? {pixel, word_q[WORD_W-1:PIXEL_DWIDTH]}
                                    : {word_q[WORD_W-PIXEL_DWIDTH-1:0], pixel};
    assign word_full = push && (pix_idx_q == IDX_W'(PIXELS_PER_WORD - 1));

    always_comb begin
        word_d    = word_q;
        pix_idx_d = pix_idx_q;
        if (clear) begin
            word_d    = '0;
            pix_idx_d = '0;
        end else if (push) begin
            word_d    = word_next;
            pix_idx_d = word_full ? '0 : pix_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            pix_idx_q <= '0;
        end else begin
            word_q    <= word_d;
            pix_idx_q <= pix_idx_d;
        end
    end
endmodule

// File: rtl/sobel_frame_writer.sv
// Drains the sobel output FIFO, packs pixels into words and writes one frame
// to sequential word addresses starting at BASE_ADDR per start pulse.
//   clock, reset  : clock, async active-low reset
//   start         : one-cycle pulse, begins a frame when idle
//   bus           : FIFO read side + memory write port (master)
//   busy          : frame in progress
//   frame_done    : one-cycle pulse after the last word is accepted
//   frame_count   : completed frames, wraps
//   cur_row/col   : position of the next pixel to be read
//
// state  | meaning
// IDLE   | waiting for start
// GATHER | popping pixels until a word is complete
// WRITE  | holding the word on the memory port until accepted
// DONE   | frame_done visible, address rewinds to BASE_ADDR
module sobel_frame_writer
    import sobel_frame_writer_pkg::*;
#(
    parameter int          IMG_WIDTH       = 720,
    parameter int          IMG_HEIGHT      = 540,
    parameter int          PIXEL_DWIDTH    = 8,
    parameter int          PIXELS_PER_WORD = 4,
    parameter int          ADDR_WIDTH      = 20,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          FRAME_CNT_WIDTH = 16,
    localparam int ROW_W  = width_of(IMG_HEIGHT),
    localparam int COL_W  = width_of(IMG_WIDTH)
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    sobel_frame_writer_if.master       bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic [ROW_W-1:0]           cur_row,
    output logic [COL_W-1:0]           cur_col
);
    localparam int TOTAL_WORDS = total_words(IMG_WIDTH, IMG_HEIGHT, PIXELS_PER_WORD);
    localparam int WC_W        = width_of(TOTAL_WORDS);
    localparam int WORD_W      = PIXEL_DWIDTH * PIXELS_PER_WORD;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    fw_state_t                  state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       frame_done_q, frame_done_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [WC_W-1:0]            word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic                       wr_en_q, wr_en_d;
    logic [WORD_W-1:0]          wr_data_q, wr_data_d;

    logic              pop;
    logic              packer_clear;
    logic [WORD_W-1:0] word_next;
    logic              word_full;

    // Pop only while gathering; the FIFO is show-ahead so in_dout is valid now.
    assign pop          = (state_q == ST_GATHER) && !bus.in_empty;
    assign bus.in_rd_en = pop;

    sobel_frame_writer_pixel_packer #(
        .PIXEL_DWIDTH   (PIXEL_DWIDTH),
        .PIXELS_PER_WORD(PIXELS_PER_WORD)
    ) u_packer (
        .clock    (clock),
        .reset    (reset),
        .push     (pop),
        .clear    (packer_clear),
        .pixel    (bus.in_dout),
        .word_next(word_next),
        .word_full(word_full)
    );

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        row_d         = row_q;
        col_d         = col_q;
        word_cnt_d    = word_cnt_q;
        addr_d        = addr_q;
        wr_en_d       = wr_en_q;
        wr_data_d     = wr_data_q;
        packer_clear  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_GATHER;
                    busy_d       = 1'b1;
                    packer_clear = 1'b1;
                    word_cnt_d   = '0;
                    row_d        = '0;
                    col_d        = '0;
                    addr_d       = BASE;
                end
            end
            ST_GATHER: begin
                if (pop) begin
                    if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                        col_d = '0;
                        // Row wraps after the final pixel so it stays in range.
                        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (word_full) begin
                        wr_data_d = word_next;
                        wr_en_d   = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_en_q && bus.mem_wr_ready) begin
                    wr_en_d = 1'b0;
                    if (word_cnt_q == WC_W'(TOTAL_WORDS - 1)) begin
                        state_d       = ST_DONE;
                        busy_d        = 1'b0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                        state_d    = ST_GATHER;
                    end
                end
            end
            ST_DONE: begin
                addr_d  = BASE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            row_q         <= '0;
            col_q         <= '0;
            word_cnt_q    <= '0;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            row_q         <= row_d;
            col_q         <= col_d;
            word_cnt_q    <= word_cnt_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign cur_row         = row_q;
    assign cur_col         = col_q;
endmodule

// File: tb/tb_sobel_frame_writer.sv
// Self-checking bench for sobel_frame_writer on a 4x2 frame, 4 pixels/word,
// base word address 0x10. The FIFO is a byte queue; a stream-level model
// derives each expected write from the popped pixel stream.
module tb_sobel_frame_writer;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int PPW   = 4;
    localparam int BASE  = 16;
    localparam int TOTAL = W * H / PPW;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [0:0]  cur_row;
    logic [1:0]  cur_col;

    always #5 clock = ~clock;

    sobel_frame_writer_if #(.PIXEL_DWIDTH(8), .PIXELS_PER_WORD(PPW), .ADDR_WIDTH(20)) bus ();

    sobel_frame_writer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_DWIDTH(8), .PIXELS_PER_WORD(PPW),
        .ADDR_WIDTH(20), .BASE_ADDR(32'h10), .FRAME_CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .cur_row(cur_row), .cur_col(cur_col)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Environment and reference model state
    logic [7:0]  fifo_q[$];
    logic [7:0]  popped[$];
    logic [31:0] cap_data[$];
    logic [19:0] cap_addr[$];
    int frame_base = 0, word_idx = 0, m_busy = 0, m_done_pend = 0, m_count = 0;
    int bubble_pct = 0, ready_pct = 100, stall_left = 0, stall_seen = 0;
    int viol_empty = 0, viol_write_pop = 0, pos_err = 0, ctl_err = 0, hold_err = 0;
    logic        prev_en = 1'b0, prev_hs = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    task automatic drive_inputs();
        logic bubble;
        bubble = ($urandom_range(99) < bubble_pct);
        bus.in_empty     = (fifo_q.size() == 0) || bubble;
        bus.in_dout      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        bus.mem_wr_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
    endtask

    task automatic tick();
        logic rd, hs, start_s;
        logic [19:0] wa;
        logic [31:0] wd, exp_w;
        int n;
        @(negedge clock);
        rd      = bus.in_rd_en;
        hs      = bus.mem_wr_en && bus.mem_wr_ready;
        start_s = start;
        wa      = bus.mem_addr;
        wd      = bus.mem_wr_data;
        if (rd && bus.in_empty) viol_empty++;
        if (rd && bus.mem_wr_en) viol_write_pop++;
        n = popped.size() - frame_base;
        if (cur_col !== 2'(n % W) || cur_row !== 1'((n / W) % H)) pos_err++;
        if (busy !== (m_busy != 0) || frame_done !== (m_done_pend != 0)) ctl_err++;
        if (bus.mem_wr_en && !bus.mem_wr_ready) begin
            stall_seen++;
            if (stall_left > 0) stall_left--;
        end
        if (prev_en && !prev_hs &&
            (bus.mem_wr_en !== 1'b1 || wa !== prev_addr || wd !== prev_data)) hold_err++;
        prev_en = bus.mem_wr_en; prev_hs = hs; prev_addr = wa; prev_data = wd;

        @(posedge clock);
        if (m_done_pend != 0) begin
            m_done_pend = 0;
        end else if (start_s && m_busy == 0) begin
            m_busy = 1; frame_base = popped.size(); word_idx = 0;
            cap_data.delete(); cap_addr.delete();
        end
        if (rd) popped.push_back(fifo_q.pop_front());
        if (hs) begin
            n = popped.size() - frame_base;
            check("wr_pixels_available", (n >= PPW * (word_idx + 1)), 1);
            exp_w = 32'hdeadbeef;
            if (n >= PPW * (word_idx + 1)) begin
                exp_w = 0;
                for (int i = 0; i < PPW; i++)
                    exp_w = exp_w | (32'(popped[frame_base + PPW * word_idx + i]) << (8 * i));
            end
            check("wr_data", wd, exp_w);
            check("wr_addr", wa, BASE + word_idx);
            cap_data.push_back(wd); cap_addr.push_back(wa);
            word_idx++;
            if (word_idx == TOTAL) begin
                m_busy = 0; m_done_pend = 1; m_count++;
            end
        end
        #1 drive_inputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame();
        int t = 0;
        while ((m_busy != 0 || m_done_pend != 0) && t < 400) begin
            tick();
            t++;
        end
        check("frame_timeout", (t >= 400), 0);
    endtask

    task automatic load_fifo(input int first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(8'(first + i));
    endtask

    task automatic check_words(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        check({tag, "_nwords"}, cap_data.size(), TOTAL);
        for (int i = 0; i < cap_data.size() && i < TOTAL; i++) begin
            check({tag, "_word"}, cap_data[i], (i == 0) ? w0 : w1);
            check({tag, "_addr"}, cap_addr[i], BASE + i);
        end
    endtask

    typedef struct {
        int          bubble_pct;
        int          ready_pct;
        int          stall;
        int          exp_stall;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_count;
    } row_t;

    row_t rows[4];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int rd_in_reset = 0;
        int t;
        rows[0] = '{0,   100, 0,  0, 32'h04030201, 32'h08070605, 1};
        rows[1] = '{0,   100, 5,  5, 32'h04030201, 32'h08070605, 2};
        rows[2] = '{50,  100, 0,  0, 32'h04030201, 32'h08070605, 3};
        rows[3] = '{40,  60,  0, -1, 32'h04030201, 32'h08070605, 4};

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            bus.in_empty     = 1'($urandom_range(1));
            bus.in_dout      = 8'($urandom_range(255));
            bus.mem_wr_ready = 1'($urandom_range(1));
            start            = 1'($urandom_range(1));
            @(negedge clock);
            if (bus.in_rd_en !== 1'b0) rd_in_reset++;
        end
        check("rst_in_rd_en", rd_in_reset, 0);
        check("rst_mem_wr_en", bus.mem_wr_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wr_data", bus.mem_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_cur_col", cur_col, 0);
        start = 1'b0;
        drive_inputs();
        reset = 1'b1;
        repeat (2) tick();

        // Table-driven frames over pixels 0x01..0x08
        for (int r = 0; r < 4; r++) begin
            fifo_q.delete();
            load_fifo(1, 8);
            bubble_pct = rows[r].bubble_pct;
            ready_pct  = rows[r].ready_pct;
            stall_left = rows[r].stall;
            stall_seen = 0;
            pulse_start();
            wait_frame();
            check_words("table", rows[r].w0, rows[r].w1);
            check("table_frame_count", frame_count, rows[r].exp_count);
            check("table_busy_after", busy, 0);
            if (rows[r].exp_stall >= 0) check("table_stall_cycles", stall_seen, rows[r].exp_stall);
            repeat (2) tick();
        end

        // Random pixel data with bubbles and backpressure; 3 extra bytes per frame stay queued
        fifo_q.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8 + 3; i++) fifo_q.push_back(8'($urandom_range(255)));
            bubble_pct = $urandom_range(70);
            ready_pct  = $urandom_range(100, 30);
            pulse_start();
            wait_frame();
            check("rand_nwords", cap_data.size(), TOTAL);
            check("rand_fifo_left", fifo_q.size(), 3 * (r + 1));
            check("rand_frame_count", frame_count, m_count);
            repeat (3) tick();
        end

        // Asynchronous reset after 6 pops; popped pixels are lost
        bubble_pct = 0; ready_pct = 100;
        fifo_q.delete();
        load_fifo(1, 16);
        pulse_start();
        t = 0;
        while ((popped.size() - frame_base) < 6 && t < 100) begin
            tick();
            t++;
        end
        check("midrst_reach_6_pops", (t >= 100), 0);
        reset = 1'b0;
        #1;
        check("midrst_mem_wr_en", bus.mem_wr_en, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        check("midrst_mem_wr_data", bus.mem_wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_cur_pos", {cur_row, cur_col}, 0);
        check("midrst_in_rd_en", bus.in_rd_en, 0);
        m_busy = 0; m_done_pend = 0; m_count = 0;
        frame_base = popped.size(); prev_en = 1'b0;
        #2 reset = 1'b1;
        repeat (2) tick();
        pulse_start();
        wait_frame();
        check_words("after_rst", 32'h0A090807, 32'h0E0D0C0B);
        check("after_rst_frame_count", frame_count, 1);
        check("after_rst_fifo_left", fifo_q.size(), 2);

        // Start while busy is ignored; then a back-to-back second frame
        fifo_q.delete();
        load_fifo(1, 16);
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_frame();
        check_words("busy_start", 32'h04030201, 32'h08070605);
        check("busy_start_frame_count", frame_count, 2);
        check("busy_start_fifo_left", fifo_q.size(), 8);
        pulse_start();
        wait_frame();
        check_words("b2b", 32'h0C0B0A09, 32'h100F0E0D);
        check("b2b_frame_count", frame_count, 3);
        check("b2b_fifo_left", fifo_q.size(), 0);
        repeat (2) tick();

        check("pop_while_empty", viol_empty, 0);
        check("pop_while_writing", viol_write_pop, 0);
        check("row_col_tracking", pos_err, 0);
        check("busy_frame_done_timing", ctl_err, 0);
        check("write_hold_stable", hold_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sobel_frame_writer.md
Name: sobel_frame_writer

Overview:
- Drains the 8-bit sobel output FIFO of the edge-detection pipeline. This is the read side of that FIFO's fifo_out_rd_en / fifo_out_dout / fifo_out_empty interface.
- Packs PIXELS_PER_WORD pixels into one memory word and writes the words to sequential word addresses starting at BASE_ADDR.
- Handles one IMG_WIDTH x IMG_HEIGHT frame per start pulse, signals completion and counts frames.

Parameters:
- IMG_WIDTH, 720, pixels per row; must be a multiple of PIXELS_PER_WORD.
- IMG_HEIGHT, 540, rows per frame.
- PIXEL_DWIDTH, 8, width of one sobel pixel.
- PIXELS_PER_WORD, 4, pixels packed per memory word.
- ADDR_WIDTH, 20, memory word-address width.
- BASE_ADDR, 0, word address of the first pixel word.
- FRAME_CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- in_rd_en  out  1  pop strobe to the sobel FIFO.
- in_dout  in  PIXEL_DWIDTH  FIFO head data; show-ahead, valid whenever in_empty=0.
- in_empty  in  1  FIFO empty.
- mem_wr_en  out  1  write request.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wr_data  out  PIXEL_DWIDTH*PIXELS_PER_WORD  packed pixels.
- mem_wr_ready  in  1  memory accepts the write this cycle.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last word is accepted.
- frame_count  out  FRAME_CNT_WIDTH  number of completed frames, wraps.
- cur_row  out  clog2(IMG_HEIGHT)  row of the next pixel to be read.
- cur_col  out  clog2(IMG_WIDTH)  column of the next pixel to be read.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_wr_en, mem_addr, mem_wr_data, busy, frame_done, frame_count, cur_row, cur_col, pixel index and word counter all clear to 0.
  - Any partial word is discarded.
- Derived constant: TOTAL_WORDS = IMG_WIDTH*IMG_HEIGHT/PIXELS_PER_WORD.
- FSM states: IDLE, GATHER, WRITE, DONE.
- IDLE:
  - On start=1: go to GATHER; busy=1; clear pix_idx, word_cnt, row and col; mem_addr=BASE_ADDR.
  - start while busy is ignored.
- GATHER:
  - in_rd_en is combinational: 1 exactly when state=GATHER and in_empty=0. It is never asserted when the FIFO is empty.
  - On each pop, in_dout is stored into lane pix_idx of the word register. Lane 0 is bits [PIXEL_DWIDTH-1:0] (little-endian).
  - col increments on each pop; it wraps to 0 at IMG_WIDTH-1, and row increments on that wrap.
  - The pop with pix_idx=PIXELS_PER_WORD-1 clears pix_idx, registers mem_wr_data and sets mem_wr_en=1 for the next cycle. The state moves to WRITE.
- WRITE:
  - mem_wr_en, mem_addr and mem_wr_data are held stable until mem_wr_ready=1.
  - No FIFO pops occur in WRITE.
  - On handshake (mem_wr_en and mem_wr_ready): mem_wr_en=0.
  - If word_cnt=TOTAL_WORDS-1, go to DONE. Otherwise increment word_cnt and mem_addr, and return to GATHER.
- DONE:
  - frame_done=1 for exactly one cycle; frame_count increments (wraps); busy=0.
  - mem_addr returns to BASE_ADDR, and the state moves to IDLE.
- Throughput: at least PIXELS_PER_WORD+1 cycles per word. mem_wr_en rises one cycle after the final pop of a word.
- An asynchronous reset mid-frame aborts the frame. Pixels already popped are lost; they are not re-read.
- Extra FIFO data after the frame stays in the FIFO until the next start.
- mem_addr never exceeds BASE_ADDR+TOTAL_WORDS-1.

Decomposition:
- Shared constants file:
  - FSM state encodings (2 bits).
  - TOTAL_WORDS computation.
  - clog2 function.
  - Packing-order definition (lane 0 = LSB).
- Sub-module pixel_packer:
  - Contents: lane shift register, pix_idx counter, word_full flag.
  - Controlled by push and clear from the FSM.
- Row/col/address counters and the FSM stay in sobel_frame_writer.

Test Plan:
1. Reset, using IMG_WIDTH=4, IMG_HEIGHT=2, PIXELS_PER_WORD=4, BASE_ADDR=0x10. Hold reset=0 with random inputs -> all outputs 0, in_rd_en=0.
2. Same config; start, then FIFO supplies 0x01..0x08; mem_wr_ready=1 -> writes 0x04030201 @0x10, then 0x08070605 @0x11. Then frame_done pulses once, frame_count=1, busy=0.
3. Backpressure: mem_wr_ready=0 for 5 cycles on the first word -> mem_wr_en/addr/data stay constant and in_rd_en=0 throughout. The write completes on the cycle ready rises.
4. Bubbles: in_empty toggles randomly -> in_rd_en is never 1 while in_empty=1. The packed words equal scenario 2; cur_col/cur_row track each pop.
5. Reset mid-frame after 6 pops -> outputs clear immediately. A new start writes 0x?? to 0x10 starting from the next FIFO pixel; word_cnt restarts at 0.
6. start pulsed while busy, then a second frame back-to-back -> the extra start has no effect. The second frame writes again at 0x10/0x11, frame_count=2.
